// File: rtl/i2c_dual_role_controller.sv
// Single-byte I2C controller: bus master on an IDRDY request, addressed slave otherwise.
// SDA/SCL are open-drain; the slave side follows the bus through 2-flop synchronizers.
`timescale 1ns/1ps
module i2c_dual_role_controller #(
    parameter int CLOCK_FREQUENCY = 100_000_000,
    parameter int I2C_FREQ        = 100_000,
    parameter int DATA_BITS       = 8
) (
    input  logic                 CLK,
    input  logic                 NRST,
    inout  logic                 I2C_SDA,
    inout  logic                 I2C_SCL,
    input  logic [DATA_BITS-1:0] IDATA,
    input  logic [6:0]           IADDR,
    input  logic                 I_RW,
    output logic [DATA_BITS-1:0] ODATA,
    output logic                 BUSY,
    output logic                 ODRDY,
    input  logic                 IDRDY
);
    localparam int DIV = CLOCK_FREQUENCY / I2C_FREQ;
    localparam int Q   = DIV / 4;
    localparam int PW  = $clog2(5 * Q + 1);
    localparam logic [PW-1:0] PH_Q    = PW'(Q);
    localparam logic [PW-1:0] PH_HALF = PW'(2 * Q - 1);
    localparam logic [PW-1:0] PH_3Q   = PW'(3 * Q);
    localparam logic [PW-1:0] PH_BIT  = PW'(4 * Q - 1);
    localparam logic [PW-1:0] PH_STOP = PW'(5 * Q - 1);
    localparam logic [3:0]    NBITS   = 4'(DATA_BITS);
    localparam logic [3:0]    LAST    = 4'(DATA_BITS - 1);

    typedef enum logic [3:0] {
        IDLE, M_START, M_ADDR, M_AACK, M_WDATA, M_WACK, M_RDATA, M_RNACK, M_STOP,
        S_ADDR, S_AACK, S_RX, S_RXACK, S_TX, S_TXACK, S_WAIT_STOP
    } state_t;

    state_t               state_reg, state_next;
    logic [PW-1:0]        ph_reg;
    logic [3:0]           bit_cnt_reg;
    logic                 sda_low_reg, scl_low_reg;
    logic [1:0]           sda_sync_reg, scl_sync_reg;
    logic                 sda_d_reg, scl_d_reg, bus_active_reg;
    logic [7:0]           addr_byte_reg;
    logic [DATA_BITS-1:0] wdata_reg, rx_sh_reg, tx_buf_reg, odata_reg;
    logic                 ack_reg, odrdy_reg;

    logic sda_s, scl_s, start_det, stop_det, scl_rise, scl_fall, busy_bus;
    logic is_mbit, is_master, is_slave, ph_end, restart;
    logic [DATA_BITS-1:0] rx_next;

    assign sda_s     = sda_sync_reg[1];
    assign scl_s     = scl_sync_reg[1];
    assign start_det = scl_s & scl_d_reg & sda_d_reg & ~sda_s;
    assign stop_det  = scl_s & scl_d_reg & ~sda_d_reg & sda_s;
    assign scl_rise  = scl_s & ~scl_d_reg;
    assign scl_fall  = ~scl_s & scl_d_reg;
    // The raw lines catch a START that is still inside the synchronizers.
    assign busy_bus  = (~I2C_SDA & I2C_SCL) | bus_active_reg;
    assign is_mbit   = state_reg inside {M_ADDR, M_AACK, M_WDATA, M_WACK, M_RDATA, M_RNACK};
    assign is_master = is_mbit || state_reg == M_START || state_reg == M_STOP;
    assign is_slave  = state_reg inside {S_ADDR, S_AACK, S_RX, S_RXACK, S_TX, S_TXACK, S_WAIT_STOP};
    assign ph_end    = ph_reg == PH_BIT;
    assign restart   = is_slave && start_det;
    assign rx_next   = {rx_sh_reg[DATA_BITS-2:0], sda_s};

    assign I2C_SDA = sda_low_reg ? 1'b0 : 1'bz;
    assign I2C_SCL = scl_low_reg ? 1'b0 : 1'bz;
    assign ODATA   = odata_reg;
    assign BUSY    = state_reg != IDLE;
    assign ODRDY   = odrdy_reg;

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:      if (IDRDY && !busy_bus) state_next = M_START;
                       else if (start_det)     state_next = S_ADDR;
            M_START:   if (ph_reg == PH_HALF) state_next = M_ADDR;
            M_ADDR:    if (ph_end && bit_cnt_reg == 4'd7) state_next = M_AACK;
            M_AACK:    if (ph_end) state_next = ack_reg ? M_STOP : (addr_byte_reg[0] ? M_RDATA : M_WDATA);
            M_WDATA:   if (ph_end && bit_cnt_reg == LAST) state_next = M_WACK;
            M_RDATA:   if (ph_end && bit_cnt_reg == LAST) state_next = M_RNACK;
            M_WACK, M_RNACK: if (ph_end) state_next = M_STOP;
            M_STOP:    if (ph_reg == PH_STOP) state_next = IDLE;
            S_ADDR:    if (scl_fall && bit_cnt_reg == 4'd8)
                           state_next = (rx_sh_reg[7:1] == IADDR) ? S_AACK : S_WAIT_STOP;
            S_AACK:    if (scl_fall) state_next = rx_sh_reg[0] ? S_TX : S_RX;
            S_RX:      if (scl_fall && bit_cnt_reg == NBITS) state_next = S_RXACK;
            S_TX:      if (scl_fall && bit_cnt_reg == NBITS) state_next = S_TXACK;
            S_RXACK, S_TXACK: if (scl_fall) state_next = S_WAIT_STOP;
            default:   ;
        endcase
        if (is_slave) begin
            if (stop_det)       state_next = IDLE;
            else if (start_det) state_next = S_ADDR;
        end
    end

    always_ff @(posedge CLK or negedge NRST) begin
        if (!NRST) begin
            state_reg      <= IDLE;
            ph_reg         <= '0;
            bit_cnt_reg    <= '0;
            sda_low_reg    <= 1'b0;
            scl_low_reg    <= 1'b0;
            sda_sync_reg   <= 2'b11;
            scl_sync_reg   <= 2'b11;
            sda_d_reg      <= 1'b1;
            scl_d_reg      <= 1'b1;
            bus_active_reg <= 1'b0;
            addr_byte_reg  <= '0;
            wdata_reg      <= '0;
            rx_sh_reg      <= '0;
            tx_buf_reg     <= '0;
            odata_reg      <= '0;
            ack_reg        <= 1'b0;
            odrdy_reg      <= 1'b0;
        end else begin
            state_reg    <= state_next;
            sda_sync_reg <= {sda_sync_reg[0], I2C_SDA};
            scl_sync_reg <= {scl_sync_reg[0], I2C_SCL};
            sda_d_reg    <= sda_s;
            scl_d_reg    <= scl_s;
            odrdy_reg    <= 1'b0;
            if (start_det)     bus_active_reg <= 1'b1;
            else if (stop_det) bus_active_reg <= 1'b0;
            if (state_reg == IDLE || IDRDY) tx_buf_reg <= IDATA;
            if (state_reg == IDLE && IDRDY && !busy_bus) begin
                addr_byte_reg <= {IADDR, I_RW};
                wdata_reg     <= IDATA;
            end
            if (state_next != state_reg || restart) begin
                ph_reg      <= '0;
                bit_cnt_reg <= '0;
                scl_low_reg <= state_next inside {M_ADDR, M_AACK, M_WDATA, M_WACK,
                                                  M_RDATA, M_RNACK, M_STOP};
                // Master SDA only moves at mid-low, so master-to-master hops keep it.
                case (state_next)
                    M_START, S_AACK, S_RXACK: sda_low_reg <= 1'b1;
                    S_TX:                     sda_low_reg <= ~tx_buf_reg[DATA_BITS-1];
                    M_ADDR, M_AACK, M_WDATA, M_WACK, M_RDATA, M_RNACK, M_STOP:
                                              sda_low_reg <= sda_low_reg;
                    default:                  sda_low_reg <= 1'b0;
                endcase
            end else begin
                if (is_master) ph_reg <= (is_mbit && ph_end) ? '0 : ph_reg + 1'b1;
                case (state_reg)
                    M_ADDR, M_AACK, M_WDATA, M_WACK, M_RDATA, M_RNACK: begin
                        if (ph_reg == PH_Q)
                            sda_low_reg <= (state_reg == M_ADDR)  ? ~addr_byte_reg[~bit_cnt_reg[2:0]] :
                                           (state_reg == M_WDATA) ? ~wdata_reg[~bit_cnt_reg[2:0]] : 1'b0;
                        if (ph_reg == PH_HALF) scl_low_reg <= 1'b0;
                        if (ph_end) begin
                            scl_low_reg <= 1'b1;
                            bit_cnt_reg <= bit_cnt_reg + 1'b1;
                        end
                        if (ph_reg == PH_3Q && state_reg == M_AACK) ack_reg <= sda_s;
                        if (ph_reg == PH_3Q && state_reg == M_RDATA) begin
                            rx_sh_reg <= rx_next;
                            if (bit_cnt_reg == LAST) begin
                                odata_reg <= rx_next;
                                odrdy_reg <= 1'b1;
                            end
                        end
                    end
                    M_STOP: begin
                        if (ph_reg == PH_Q)    sda_low_reg <= 1'b1;
                        if (ph_reg == PH_HALF) scl_low_reg <= 1'b0;
                        if (ph_reg == PH_3Q)   sda_low_reg <= 1'b0;
                    end
                    S_ADDR, S_RX: if (scl_rise) begin
                        rx_sh_reg   <= rx_next;
                        bit_cnt_reg <= bit_cnt_reg + 1'b1;
                        if (state_reg == S_RX && bit_cnt_reg == LAST) begin
                            odata_reg <= rx_next;
                            odrdy_reg <= 1'b1;
                        end
                    end
                    S_TX: begin
                        if (scl_rise) bit_cnt_reg <= bit_cnt_reg + 1'b1;
                        if (scl_fall) sda_low_reg <= ~tx_buf_reg[~bit_cnt_reg[2:0]];
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_i2c_dual_role_controller.sv
// Two controllers on one pulled-up bus: u_master issues transfers, u_slave answers address 0x50.
`timescale 1ns/1ps
module tb_i2c_dual_role_controller;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n = 1'b0;
    wire  sda, scl;
    pullup (sda);
    pullup (scl);

    logic [7:0] m_idata = '0, s_idata = '0;
    logic [6:0] m_iaddr = '0, s_iaddr = 7'h50;
    logic       m_rw = 1'b0, s_rw = 1'b0, m_idrdy = 1'b0, s_idrdy = 1'b0;
    logic [7:0] m_odata, s_odata;
    logic       m_busy, s_busy, m_odrdy, s_odrdy;

    i2c_dual_role_controller #(.CLOCK_FREQUENCY(100_000_000), .I2C_FREQ(2_500_000), .DATA_BITS(8)) u_master (
        .CLK(clk), .NRST(rst_n), .I2C_SDA(sda), .I2C_SCL(scl), .IDATA(m_idata), .IADDR(m_iaddr),
        .I_RW(m_rw), .ODATA(m_odata), .BUSY(m_busy), .ODRDY(m_odrdy), .IDRDY(m_idrdy));
    i2c_dual_role_controller #(.CLOCK_FREQUENCY(100_000_000), .I2C_FREQ(2_500_000), .DATA_BITS(8)) u_slave (
        .CLK(clk), .NRST(rst_n), .I2C_SDA(sda), .I2C_SCL(scl), .IDATA(s_idata), .IADDR(s_iaddr),
        .I_RW(s_rw), .ODATA(s_odata), .BUSY(s_busy), .ODRDY(s_odrdy), .IDRDY(s_idrdy));

    // Bus monitor: START/STOP counts and 9-bit frames (byte + ack) on SCL rising edges.
    logic       sda_p = 1'b1, scl_p = 1'b1;
    logic [8:0] msh = '0;
    int         mbits = 0, starts = 0, stops = 0, m_pulses = 0, s_pulses = 0;
    logic [7:0] bytes_q[$];
    logic       acks_q[$];
    always @(negedge clk) begin
        if (scl && scl_p && sda_p && !sda) begin
            starts++;
            mbits = 0;
        end else if (scl && scl_p && !sda_p && sda) begin
            stops++;
        end else if (scl && !scl_p) begin
            msh = {msh[7:0], sda};
            mbits++;
            if (mbits == 9) begin
                bytes_q.push_back(msh[8:1]);
                acks_q.push_back(msh[0]);
                mbits = 0;
            end
        end
        if (m_odrdy) m_pulses++;
        if (s_odrdy) s_pulses++;
        sda_p = sda;
        scl_p = scl;
    end

    int total = 0, bad = 0;
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // IDRDY at negedge N0; returns at N1 after checking BUSY rose on the intervening edge.
    task automatic start_xfer(input logic [6:0] addr, input logic rw, input logic [7:0] md, input logic [7:0] sd);
        @(negedge clk);
        m_iaddr = addr; m_rw = rw; m_idata = md; s_idata = sd; m_idrdy = 1'b1;
        @(negedge clk);
        m_idrdy = 1'b0;
        if (rw) s_idrdy = 1'b1;
        chk("busy_after_idrdy", {31'b0, m_busy}, 1);
    endtask

    task automatic wait_idle(output int cyc);
        cyc = 0;
        while (m_busy && cyc < 5000) begin
            cyc++;
            @(negedge clk);
            s_idrdy = 1'b0;
        end
    endtask

    typedef struct {
        logic [6:0] addr; logic rw; logic [7:0] mdata; logic [7:0] sdata;
        int nbytes; logic [7:0] b0; logic a0; logic [7:0] b1; logic a1;
        logic [7:0] exp_m; logic [7:0] exp_s; int m_rdy; int s_rdy;
    } vec_t;
    vec_t vecs[6];

    int s0, p0, q0, mr0, sr0, cyc;

    initial begin
        vecs[0] = '{7'h50, 1'b0, 8'hA5, 8'h00, 2, 8'hA0, 1'b0, 8'hA5, 1'b0, 8'h00, 8'hA5, 0, 1};
        vecs[1] = '{7'h50, 1'b1, 8'h00, 8'h55, 2, 8'hA1, 1'b0, 8'h55, 1'b1, 8'h55, 8'hA5, 1, 0};
        vecs[2] = '{7'h51, 1'b0, 8'h77, 8'h00, 1, 8'hA2, 1'b1, 8'h00, 1'b0, 8'h55, 8'hA5, 0, 0};
        vecs[3] = '{7'h50, 1'b0, 8'h3C, 8'h00, 2, 8'hA0, 1'b0, 8'h3C, 1'b0, 8'h55, 8'h3C, 0, 1};
        vecs[4] = '{7'h50, 1'b1, 8'h00, 8'hC3, 2, 8'hA1, 1'b0, 8'hC3, 1'b1, 8'hC3, 8'h3C, 1, 0};
        vecs[5] = '{7'h2A, 1'b1, 8'h00, 8'h99, 1, 8'h55, 1'b1, 8'h00, 1'b0, 8'hC3, 8'h3C, 0, 0};

        #10;
        chk("rst_m_odata", {24'b0, m_odata}, 0);
        chk("rst_s_odata", {24'b0, s_odata}, 0);
        chk("rst_m_busy", {31'b0, m_busy}, 0);
        chk("rst_s_busy", {31'b0, s_busy}, 0);
        chk("rst_m_odrdy", {31'b0, m_odrdy}, 0);
        chk("rst_sda", {31'b0, sda}, 1);
        chk("rst_scl", {31'b0, scl}, 1);
        #10 rst_n = 1'b1;
        repeat (5) @(negedge clk);

        for (int i = 0; i < 6; i++) begin
            s0 = starts; p0 = stops; q0 = bytes_q.size(); mr0 = m_pulses; sr0 = s_pulses;
            start_xfer(vecs[i].addr, vecs[i].rw, vecs[i].mdata, vecs[i].sdata);
            wait_idle(cyc);
            repeat (40) @(negedge clk);
            chk("busy_len", cyc, 70 + 360 * vecs[i].nbytes);
            chk("starts", starts - s0, 1);
            chk("stops", stops - p0, 1);
            chk("nbytes", bytes_q.size() - q0, vecs[i].nbytes);
            if (bytes_q.size() > q0) begin
                chk("byte0", {24'b0, bytes_q[q0]}, {24'b0, vecs[i].b0});
                chk("ack0", {31'b0, acks_q[q0]}, {31'b0, vecs[i].a0});
            end
            if (vecs[i].nbytes == 2 && bytes_q.size() > q0 + 1) begin
                chk("byte1", {24'b0, bytes_q[q0+1]}, {24'b0, vecs[i].b1});
                chk("ack1", {31'b0, acks_q[q0+1]}, {31'b0, vecs[i].a1});
            end
            chk("m_odata", {24'b0, m_odata}, {24'b0, vecs[i].exp_m});
            chk("s_odata", {24'b0, s_odata}, {24'b0, vecs[i].exp_s});
            chk("m_odrdy_cnt", m_pulses - mr0, vecs[i].m_rdy);
            chk("s_odrdy_cnt", s_pulses - sr0, vecs[i].s_rdy);
            chk("s_busy_end", {31'b0, s_busy}, 0);
            $display("xfer %0d addr=%h rw=%b busy_cycles=%0d m_odata=%h s_odata=%h", i,
                     vecs[i].addr, vecs[i].rw, cyc, m_odata, s_odata);
        end

        // IDRDY while busy: no second START, transfer keeps its latched address/data.
        s0 = starts; p0 = stops; q0 = bytes_q.size();
        start_xfer(7'h50, 1'b0, 8'hA5, 8'h00);
        repeat (200) @(negedge clk);
        m_iaddr = 7'h51; m_rw = 1'b1; m_idata = 8'hFF; m_idrdy = 1'b1;
        @(negedge clk);
        m_idrdy = 1'b0;
        wait_idle(cyc);
        repeat (100) @(negedge clk);
        chk("busy_req_starts", starts - s0, 1);
        chk("busy_req_stops", stops - p0, 1);
        chk("busy_req_nbytes", bytes_q.size() - q0, 2);
        if (bytes_q.size() > q0 + 1) begin
            chk("busy_req_byte0", {24'b0, bytes_q[q0]}, 32'hA0);
            chk("busy_req_byte1", {24'b0, bytes_q[q0+1]}, 32'hA5);
        end
        chk("busy_req_s_odata", {24'b0, s_odata}, 32'hA5);
        chk("busy_req_idle", {31'b0, m_busy}, 0);
        $display("xfer busy_request starts=%0d s_odata=%h", starts - s0, s_odata);

        // Reset in the middle of the data byte, then a clean transfer.
        start_xfer(7'h50, 1'b0, 8'h0F, 8'h00);
        repeat (480) @(negedge clk);
        chk("mid_busy_before_rst", {31'b0, m_busy}, 1);
        rst_n = 1'b0;
        #2;
        chk("mid_rst_sda", {31'b0, sda}, 1);
        chk("mid_rst_scl", {31'b0, scl}, 1);
        chk("mid_rst_m_busy", {31'b0, m_busy}, 0);
        chk("mid_rst_s_busy", {31'b0, s_busy}, 0);
        chk("mid_rst_s_odata", {24'b0, s_odata}, 0);
        #18 rst_n = 1'b1;
        repeat (5) @(negedge clk);
        s0 = starts; p0 = stops; q0 = bytes_q.size(); sr0 = s_pulses;
        start_xfer(7'h50, 1'b0, 8'h5A, 8'h00);
        wait_idle(cyc);
        repeat (40) @(negedge clk);
        chk("post_rst_busy_len", cyc, 790);
        chk("post_rst_starts", starts - s0, 1);
        chk("post_rst_nbytes", bytes_q.size() - q0, 2);
        if (bytes_q.size() > q0 + 1) begin
            chk("post_rst_byte0", {24'b0, bytes_q[q0]}, 32'hA0);
            chk("post_rst_byte1", {24'b0, bytes_q[q0+1]}, 32'h5A);
        end
        chk("post_rst_s_odata", {24'b0, s_odata}, 32'h5A);
        chk("post_rst_s_odrdy", s_pulses - sr0, 1);
        $display("xfer post_reset busy_cycles=%0d s_odata=%h", cyc, s_odata);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #3ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
